topk_drain: RTL

TOPK_DRAIN -- requirements
Module: topk_drain

---
 rtl/topk_pkg.sv | 12 +
 rtl/topk_cell.sv | 30 +++
 rtl/topk_drain.sv | 115 +++++++++++
 3 files changed

// File: rtl/topk_pkg.sv
// Shared definitions for the top-K collect/drain block.
package topk_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  localparam int unsigned K_MIN = 2;
  localparam int unsigned K_MAX = 16;

endpackage

// File: rtl/topk_cell.sv
// One slot of the sorted table: holds, loads din, or takes the upper neighbour's value.
module topk_cell #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  vacant,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  upper_ge,
  input  logic [DATA_WIDTH-1:0] upper_val,
  output logic                  ge,
  output logic [DATA_WIDTH-1:0] val
);

  // Vacant slots always accept, so the insertion point never passes count.
  assign ge = vacant || (din >= val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (en && ge) begin
      val <= upper_ge ? upper_val : din;
    end
  end

endmodule

// File: rtl/topk_drain.sv
// Keeps the K largest samples sorted and streams them out largest-first on request.
module topk_drain
  import topk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K          = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  input  logic                     drain,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic [$clog2(K+1)-1:0]   count,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned IW = $clog2(K);

  state_t                state_q, state_d;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] e  [K];
  logic [K-1:0]          ge;

  logic          accept;
  logic [CW-1:0] count_ins;
  logic          last_hit;
  logic          hs;
  logic          clr;

  assign accept    = (state_q == COLLECT) && din_valid;
  assign count_ins = (accept && (count != CW'(K))) ? count + CW'(1) : count;
  assign last_hit  = (CW'(rd_idx) == (count - CW'(1)));
  assign hs        = dout_valid && dout_ready;
  assign clr       = (state_q == DRAIN) && hs && last_hit;

  for (genvar i = 0; i < K; i++) begin : g_cell
    logic                  upper_ge;
    logic [DATA_WIDTH-1:0] upper_val;
    if (i == 0) begin : g_top
      assign upper_ge  = 1'b0;
      assign upper_val = '0;
    end else begin : g_rest
      assign upper_ge  = ge[i-1];
      assign upper_val = e[i-1];
    end

    topk_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .en        (accept),
      .clr       (clr),
      .vacant    (CW'(i) >= count),
      .din       (din),
      .upper_ge  (upper_ge),
      .upper_val (upper_val),
      .ge        (ge[i]),
      .val       (e[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (drain && (count_ins != '0)) state_d = DRAIN;
      DRAIN:   if (hs && last_hit) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_idx <= '0;
    end else if (state_q == COLLECT) begin
      count  <= count_ins;
      rd_idx <= '0;
    end else if (hs) begin
      if (last_hit) begin
        count  <= '0;
        rd_idx <= '0;
      end else begin
        rd_idx <= rd_idx + IW'(1);
      end
    end
  end

  always_comb begin
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    dout       = e[0];
    if (state_q == DRAIN) begin
      dout_valid = 1'b1;
      dout_last  = last_hit;
      busy       = 1'b1;
      dout       = e[rd_idx];
    end
  end

endmodule
